// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_alu : RV32I single-cycle ALU plus iterative RV32M mul/div behind a    |
// |           valid/ready handshake. Optional divider: SEQ_ALU_DIV_EN.        |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module seq_alu #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [4:0]   sel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         z_flag,
   output logic         v_flag,
   output logic         s_flag,
   output logic         c_flag
);

   localparam int              SW   = $clog2(N);
   localparam logic [SW-1:0]   LAST = SW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] cnt;
   logic [N-1:0]  hi, lo, opnd;
   logic [1:0]    mop;
   logic          neg_hi;

   logic          sub_op, f_c, f_s, f_z, f_v;
   logic [N-1:0]  addend, base_res, fix_res, mag_a, mag_b;
   logic [N:0]    sum, madd;
   logic [SW-1:0] shamt;
   logic          mul_sel, div_sel, m_calc, a_sgn, b_sgn, sa, sb;
   logic [2*N-1:0] prod_raw, prod_fix;

`ifdef SEQ_ALU_DIV_EN
   logic          is_div, neg_lo, div_zero;
   logic [N:0]    dtmp, ddif;
   logic [N-1:0]  quo, rem;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Single-cycle base datapath; flags always come from the adder.
   always_comb begin
      sub_op   = (sel[3:0] != 4'b0000);
      addend   = sub_op ? ~b : b;
      sum      = {1'b0, a} + {1'b0, addend} + {{N{1'b0}}, sub_op};
      f_c      = sum[N];
      f_s      = sum[N-1];
      f_z      = (sum[N-1:0] == '0);
      f_v      = (a[N-1] == addend[N-1]) && (sum[N-1] != a[N-1]);
      shamt    = b[SW-1:0];
      base_res = b;
      case (sel[3:0])
         4'b0000, 4'b0001: base_res = sum[N-1:0];
         4'b0100:          base_res = a | b;
         4'b0101:          base_res = a & b;
         4'b0111:          base_res = a ^ b;
         4'b1000:          base_res = a >> shamt;
         4'b1001:          base_res = a << shamt;
         4'b1010:          base_res = $unsigned($signed(a) >>> shamt);
         4'b1101:          base_res = {{(N-1){1'b0}}, f_s ^ f_v};
         4'b1111:          base_res = {{(N-1){1'b0}}, ~f_c};
         default:          base_res = b;
      endcase
   end

   always_comb begin
      mul_sel = sel[4] & ~sel[3] & ~sel[2];
`ifdef SEQ_ALU_DIV_EN
      div_sel = sel[4] & ~sel[3] & sel[2];
`else
      div_sel = 1'b0;
`endif
      m_calc  = mul_sel | div_sel;
      a_sgn   = (mul_sel & (sel[1] ^ sel[0])) | (div_sel & ~sel[0]);
      b_sgn   = (mul_sel & ~sel[1] & sel[0]) | (div_sel & ~sel[0]);
      sa      = a_sgn & a[N-1];
      sb      = b_sgn & b[N-1];
      mag_a   = sa ? -a : a;
      mag_b   = sb ? -b : b;
   end

   // Iteration step and final sign correction; hi:lo is shared by mul and div.
   always_comb begin
      madd     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {N{1'b0}})};
      prod_raw = {hi, lo};
      prod_fix = neg_hi ? -prod_raw : prod_raw;
      fix_res  = (mop == 2'b00) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
`ifdef SEQ_ALU_DIV_EN
      dtmp     = {hi, lo[N-1]};
      ddif     = dtmp - {1'b0, opnd};
      quo      = div_zero ? {N{1'b1}} : (neg_hi ? -lo : lo);
      rem      = neg_lo ? -hi : hi;
      if (is_div)
         fix_res = mop[1] ? rem : quo;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = m_calc ? CALC : DONE;
         CALC: if (cnt == LAST) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         z_flag <= 1'b0;
         v_flag <= 1'b0;
         s_flag <= 1'b0;
         c_flag <= 1'b0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         opnd   <= '0;
         mop    <= 2'b00;
         neg_hi <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         div_zero <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (m_calc) begin
                     cnt    <= '0;
                     hi     <= '0;
                     lo     <= mul_sel ? mag_b : mag_a;
                     opnd   <= mul_sel ? mag_a : mag_b;
                     mop    <= sel[1:0];
                     neg_hi <= sa ^ sb;
`ifdef SEQ_ALU_DIV_EN
                     is_div   <= div_sel;
                     neg_lo   <= sa;
                     div_zero <= (b == '0);
`endif
                  end else if (sel[4]) begin
                     // Unimplemented M codes: pass B with M-style flags.
                     result <= b;
                     z_flag <= (b == '0);
                     v_flag <= 1'b0;
                     s_flag <= 1'b0;
                     c_flag <= 1'b0;
                  end else begin
                     result <= base_res;
                     z_flag <= f_z;
                     v_flag <= f_v;
                     s_flag <= f_s;
                     c_flag <= f_c;
                  end
               end
            end
            CALC: begin
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
`ifdef SEQ_ALU_DIV_EN
               if (is_div) begin
                  hi <= ddif[N] ? dtmp[N-1:0] : ddif[N-1:0];
                  lo <= {lo[N-2:0], ~ddif[N]};
               end else begin
                  hi <= madd[N:1];
                  lo <= {madd[0], lo[N-1:1]};
               end
`else
               hi <= madd[N:1];
               lo <= {madd[0], lo[N-1:1]};
`endif
            end
            FIX: begin
               result <= fix_res;
               z_flag <= (fix_res == '0);
               v_flag <= 1'b0;
               s_flag <= 1'b0;
               c_flag <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_alu : directed self-checking bench for seq_alu (N=32).             |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_seq_alu;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a, b;
   logic [4:0]   sel;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         z_flag, v_flag, s_flag, c_flag;

   int compared   = 0;
   int mismatched = 0;
   int lat;

   seq_alu #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .z_flag    (z_flag),
      .v_flag    (v_flag),
      .s_flag    (s_flag),
      .c_flag    (c_flag)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] flags();
      return {28'd0, z_flag, v_flag, s_flag, c_flag};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input string tag, input logic [4:0] s,
                           input logic [31:0] av, input logic [31:0] bv);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      sel      = s;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a        = 32'hDEAD_BEEF;
      b        = 32'h1234_5678;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic retire(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_retire_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [4:0] s,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input logic [3:0] exp_zvsc,
                         input int exp_lat);
      start_op(tag, s, av, bv);
      wait_done(tag, exp_lat);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_flags"}, flags(), {28'd0, exp_zvsc});
      retire(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sel = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result",    result,         32'd0);
      chk("rst_flags",     flags(),        32'd0);

      // Base ops; flags are {z,v,s,c}
      run_op("add",   5'b00000, 32'h0000_0007, 32'hFFFF_FFF9, 32'h0000_0000, 4'b1001, 1);
      run_op("sub",   5'b00001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0101, 1);
      run_op("sra",   5'b01010, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b0101, 1);
      run_op("slt",   5'b01101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0011, 1);
      run_op("xor",   5'b00111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 4'b0011, 1);
      run_op("passb", 5'b00010, 32'h0000_0005, 32'h0000_ABCD, 32'h0000_ABCD, 4'b0010, 1);
      run_op("sll",   5'b01001, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 4'b0000, 1);

      // Multiply
      run_op("mul",    5'b10000, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 4'b0000, 34);
      run_op("mulh",   5'b10001, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 4'b0000, 34);
      run_op("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 4'b0000, 34);
      run_op("mulhu",  5'b10011, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 4'b0000, 34);
      run_op("mulz",   5'b10000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1000, 34);
      run_op("mhneg",  5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4'b0000, 34);
      run_op("m11",    5'b11010, 32'h0000_0001, 32'h0000_0077, 32'h0000_0077, 4'b0000, 1);

`ifdef SEQ_ALU_DIV_EN
      run_op("div0",   5'b10100, 32'd100,        32'd0,        32'hFFFF_FFFF, 4'b0000, 34);
      run_op("rem0",   5'b10110, 32'd100,        32'd0,        32'h0000_0064, 4'b0000, 34);
      run_op("divov",  5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0000, 34);
      run_op("remov",  5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 34);
      run_op("divneg", 5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 4'b0000, 34);
      run_op("remneg", 5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0000, 34);
      run_op("divu",   5'b10101, 32'd100,        32'd7,        32'd14,        4'b0000, 34);
      run_op("remu",   5'b10111, 32'd100,        32'd7,        32'd2,         4'b0000, 34);
`else
      run_op("div_nd", 5'b10100, 32'd100,        32'd0,        32'h0000_0000, 4'b1000, 1);
      run_op("rem_nd", 5'b10110, 32'd5,          32'd9,        32'h0000_0009, 4'b0000, 1);
`endif

      // Back-pressure: result and flags hold while out_ready is low
      start_op("sltu", 5'b01111, 32'd1, 32'd2);
      wait_done("sltu", 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         sel      = 5'b00000;
         a        = 32'(i);
         b        = 32'(i + 40);
         tick();
         chk("hold_result",    result,          32'd1);
         chk("hold_flags",     flags(),         32'h0000_0002);
         chk("hold_in_ready",  32'(in_ready),   32'd0);
         chk("hold_out_valid", 32'(out_valid),  32'd1);
      end
      in_valid = 1'b0;
      retire("sltu");
      chk("sltu_out_valid_after", 32'(out_valid), 32'd0);

      // Reset mid-CALC discards the multiply
      start_op("abort", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) tick();
      chk("abort_busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready",  32'(in_ready),  32'd1);
      chk("abort_result",    result,         32'd0);
      run_op("add_after", 5'b00000, 32'd2, 32'd3, 32'd5, 4'b0000, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
